serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial, LSB-first subtractor: computes diff = a - b over WIDTH cycles.
//   One full-subtractor cell (two half subtractors) per cycle, borrow in a flop.
//   Upstream: a word-level requester that issues start. Downstream: any consumer
//   that samples diff/borrow_out on done.
// PARAMETERS
//   WIDTH     8   operand/result width in bits (>= 2)
// PORTS
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous, active-high reset
//   start       in   1       request; sampled only in IDLE
//   a           in   WIDTH   minuend; captured on accepted start
//   b           in   WIDTH   subtrahend; captured on accepted start
//   busy        out  1       high while in SHIFT
//   done        out  1       one-cycle pulse: diff/borrow_out valid
//   diff        out  WIDTH   a - b modulo 2^WIDTH
//   borrow_out  out  1       1 when a < b (unsigned)
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE; busy=0, done=0, diff=0, borrow_out=0;
//     operand shift regs, bit counter, borrow flop all cleared.
//   FSM states: IDLE, SHIFT, DONE.
//   IDLE: start=1 at edge k -> load a_sr<=a, b_sr<=b, borrow<=0, cnt<=0;
//     -> SHIFT. start=0 -> stay IDLE.
//   SHIFT (edges k+1..k+WIDTH): cell inputs a_sr[0], b_sr[0], borrow:
//     d    = a0 ^ b0 ^ bin
//     bout = (~a0 & b0) | (~(a0 ^ b0) & bin)
//     diff_sr <= {d, diff_sr[WIDTH-1:1]}; a_sr,b_sr >>= 1; borrow <= bout; cnt++.
//     On the edge where cnt==WIDTH-1 -> DONE; diff <= final diff_sr,
//     borrow_out <= final bout (registered in same edge).
//   DONE: done=1 for exactly one cycle, busy=0; next edge -> IDLE.
//   Latency: start accepted at edge k -> done high in cycle after edge
//     k+WIDTH. Throughput: one op per WIDTH+2 cycles.
//   diff/borrow_out hold their last value until the next DONE; not modified
//     during SHIFT (internal diff_sr is separate).
//   start while busy or in DONE: ignored, no queuing; a/b changes after
//     acceptance have no effect.
//   start high in IDLE on the cycle right after DONE: accepted normally.
//   rst asserted mid-SHIFT: operation abandoned, all outputs to reset values,
//     no done pulse.
//   cnt width: $clog2(WIDTH); wrap never reached (exit at WIDTH-1).
// STRUCTURE
//   Package serial_sub_pkg: state encoding localparams ST_IDLE=2'd0,
//     ST_SHIFT=2'd1, ST_DONE=2'd2.
//   Sub-module full_sub_cell (a, b, bin -> d, bout): two half subtractor
//     instances + OR of borrows; purely combinational, reused elsewhere.
//   Top: FSM, counter, three shift regs, borrow flop, output regs.
// TESTING (WIDTH=8)
//   a=0x05, b=0x03, start 1 cycle -> busy 8 cycles, done at +9: diff=0x02,
//     borrow_out=0.
//   a=0x03, b=0x05 -> diff=0xFE, borrow_out=1.
//   a=0x00, b=0xFF -> diff=0x01, borrow_out=1; a=0xAA, b=0xAA -> diff=0x00,
//     borrow_out=0.
//   Start 0x10-0x01, pulse start with 0xFF-0x00 at cycle 3 of SHIFT -> single
//     done, diff=0x0F; second start ignored.
//   Back-to-back: start held high continuously -> done every 10 cycles,
//     results match each captured operand pair.
//   rst pulse at cycle 4 of SHIFT -> busy=0, done never pulses, diff=0x00,
//     borrow_out=0; next start completes normally.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/full_sub_cell.sv
// Full subtractor cell built from two half subtractors: a - b - bin.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic bo1;
    logic bo2;

    half_sub u_hs_ab (
        .x  (a),
        .y  (b),
        .d  (d1),
        .bo (bo1)
    );

    half_sub u_hs_bin (
        .x  (d1),
        .y  (bin),
        .d  (d),
        .bo (bo2)
    );

    // either stage can generate the outgoing borrow, never both at once
    assign bout = bo1 | bo2;

endmodule

// File: rtl/half_sub.sv
// Half subtractor: x - y with borrow, no borrow-in.
module half_sub (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    // difference bit and borrow generated when x=0, y=1
    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b over WIDTH cycles,
// one full-subtractor cell per cycle with the borrow carried in a flop.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on accepted start
// SHIFT  | one bit per cycle through the cell, busy high
// DONE   | one-cycle done pulse, diff/borrow_out valid
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    // only WIDTH-1 bits are kept: the final bit goes straight to the output
    logic [WIDTH-2:0] diff_sr_q;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;

    logic             diff_bit_d;
    logic             borrow_d;
    logic [WIDTH-1:0] diff_cat;

    full_sub_cell u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (diff_bit_d),
        .bout (borrow_d)
    );

    // new bit enters at the top; after WIDTH shifts this is the full result
    assign diff_cat = {diff_bit_d, diff_sr_q};

    // FSM, operand/result shift registers, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            diff_sr_q    <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr_q    <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q    <= {1'b0, b_sr_q[WIDTH-1:1]};
                    diff_sr_q <= diff_cat[WIDTH-1:1];
                    borrow_q  <= borrow_d;
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        diff_q       <= diff_cat;
                        borrow_out_q <= borrow_d;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule
